// File: rtl/wb_regfile_if.sv
// Writeback/decode bus for wb_regfile: MEM/WB writeback inputs, decode read ports, forwarding result.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              regwrite_w;
    logic              memtoreg_w;
    logic [DATA_W-1:0] readdata_w;
    logic [DATA_W-1:0] execout_w;
    logic [ADDR_W-1:0] writereg_w;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] result_w;
    logic [CNT_W-1:0]  wb_count;

    modport master (
        output regwrite_w, memtoreg_w, readdata_w, execout_w, writereg_w, ra1, ra2,
        input  rd1, rd2, result_w, wb_count
    );

    modport slave (
        input  regwrite_w, memtoreg_w, readdata_w, execout_w, writereg_w, ra1, ra2,
        output rd1, rd2, result_w, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux plus 2**ADDR_W-entry register file with two async read ports and a commit counter.
// Define WB_REGFILE_BYPASS_EN to forward the value being committed to the read ports in the same cycle.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  wb
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_result;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_result = wb.memtoreg_w ? wb.readdata_w : wb.execout_w;
    assign w_commit = wb.regwrite_w && (wb.writereg_w != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[wb.writereg_w] <= w_result;
            r_count               <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_rd1 = r_regs[wb.ra1];
        w_rd2 = r_regs[wb.ra2];
`ifdef WB_REGFILE_BYPASS_EN
        if (w_commit && (wb.ra1 == wb.writereg_w)) w_rd1 = w_result;
        if (w_commit && (wb.ra2 == wb.writereg_w)) w_rd2 = w_result;
`endif
        // Index 0 reads zero regardless of storage or bypass.
        if (wb.ra1 == '0) w_rd1 = '0;
        if (wb.ra2 == '0) w_rd2 = '0;
    end

    assign wb.rd1      = w_rd1;
    assign wb.rd2      = w_rd2;
    assign wb.result_w = w_result;
    assign wb.wb_count = r_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations come from a bench-side register model and are checked on pop.
module tb_wb_regfile;
    logic clk;
    logic rst_n;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) u_dut (
        .clk(clk), .reset(rst_n), .wb(bus)
    );
    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(rst_n), .wb(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;
    logic [31:0] m_rf4 [32];
    logic [3:0]  m_cnt4;
    logic [31:0] byp_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0:       obs = bus.rd1;
                1:       obs = bus.rd2;
                2:       obs = bus.result_w;
                3:       obs = bus.wb_count;
                4:       obs = {28'd0, bus4.wb_count};
                default: obs = bus4.rd1;
            endcase
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]  = '0;
            m_rf4[i] = '0;
        end
        m_cnt  = '0;
        m_cnt4 = '0;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rdata,
                         input logic [31:0] eout, input logic [4:0] wreg);
        bus.regwrite_w = we;
        bus.memtoreg_w = m2r;
        bus.readdata_w = rdata;
        bus.execout_w  = eout;
        bus.writereg_w = wreg;
    endtask

    // One rising edge: update the model from what is being driven, then idle the write enables.
    task automatic tick();
        @(posedge clk);
        if (rst_n && bus.regwrite_w && bus.writereg_w != 5'd0) begin
            m_rf[bus.writereg_w] = bus.memtoreg_w ? bus.readdata_w : bus.execout_w;
            m_cnt = m_cnt + 32'd1;
        end
        if (rst_n && bus4.regwrite_w && bus4.writereg_w != 5'd0) begin
            m_rf4[bus4.writereg_w] = bus4.memtoreg_w ? bus4.readdata_w : bus4.execout_w;
            m_cnt4 = m_cnt4 + 4'd1;
        end
        #1;
        bus.regwrite_w  = 1'b0;
        bus4.regwrite_w = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        bus.ra1 = 5'd5;
        bus.ra2 = 5'd0;
        bus4.regwrite_w = 1'b0;
        bus4.memtoreg_w = 1'b0;
        bus4.readdata_w = '0;
        bus4.execout_w  = '0;
        bus4.writereg_w = '0;
        bus4.ra1 = 5'd1;
        bus4.ra2 = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset_rd1", 0, 32'd0);
        push_exp("reset_cnt", 3, 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release commits normally.
        drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5);
        tick();
        push_exp("r5_written", 0, m_rf[5]);
        push_exp("r5_cnt", 3, m_cnt);
        check_all();

        #3 rst_n = 1'b0;
        model_reset();
        #1;
        push_exp("midrst_rd1", 0, 32'd0);
        push_exp("midrst_cnt", 3, 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_exp("postrst_r5", 0, m_rf[5]);
        check_all();

        drive(1'b1, 1'b0, 32'hAAAA5555, 32'h12345678, 5'd7);
        #1;
        push_exp("mux_exec", 2, 32'h12345678);
        check_all();
        tick();
        bus.ra1 = 5'd7;
        #1;
        push_exp("r7_rd1", 0, m_rf[7]);
        push_exp("r7_cnt", 3, m_cnt);
        check_all();

        drive(1'b1, 1'b1, 32'hAAAA5555, 32'h12345678, 5'd8);
        #1;
        push_exp("mux_load", 2, 32'hAAAA5555);
        check_all();
        tick();
        bus.ra2 = 5'd8;
        #1;
        push_exp("r8_rd2", 1, m_rf[8]);
        push_exp("r8_cnt", 3, m_cnt);
        check_all();

        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
        tick();
        bus.ra1 = 5'd0;
        #1;
        push_exp("r0_rd1", 0, 32'd0);
        push_exp("r0_cnt", 3, m_cnt);
        check_all();

        drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd9);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h22, 5'd9);
        bus.ra1 = 5'd9;
        bus.ra2 = 5'd9;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        byp_exp = 32'h22;
`else
        byp_exp = 32'h11;
`endif
        push_exp("same_cyc_rd1", 0, byp_exp);
        push_exp("same_cyc_rd2", 1, byp_exp);
        check_all();
        tick();
        push_exp("after_edge_rd1", 0, m_rf[9]);
        push_exp("after_edge_rd2", 1, m_rf[9]);
        check_all();

        drive(1'b0, 1'b0, 32'h0, 32'h5, 5'd3);
        bus.ra1 = 5'd3;
        tick();
        push_exp("we0_r3", 0, m_rf[3]);
        push_exp("we0_cnt", 3, m_cnt);
        check_all();

        for (int i = 0; i < 17; i++) begin
            bus4.regwrite_w = 1'b1;
            bus4.execout_w  = 32'h100 + i;
            bus4.writereg_w = 5'd1;
            tick();
        end
        push_exp("wrap_cnt", 4, {28'd0, m_cnt4});
        push_exp("wrap_r1", 5, m_rf4[1]);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. It selects the writeback result (load data or execute result) and commits it to a 32-entry architectural register file. It also serves the two decode-stage read ports. Sits between the MEM/WB register (source of regwrite_w, memtoreg_w, readdata_w, execout_w, writereg_w) and the ID stage / hazard logic.

Parameters:
DATA_W, 32, register and datapath width in bits
ADDR_W, 5, register index width; entry count NREGS = 2**ADDR_W
CNT_W, 32, width of the committed-write counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all state while low
regwrite_w  input  1  writeback enable from MEM/WB
memtoreg_w  input  1  1: write readdata_w, 0: write execout_w
readdata_w  input  DATA_W  load data from MEM/WB
execout_w  input  DATA_W  execute result from MEM/WB
writereg_w  input  ADDR_W  destination register index
ra1  input  ADDR_W  read port 1 index (decode rs)
ra2  input  ADDR_W  read port 2 index (decode rt)
rd1  output  DATA_W  read port 1 data
rd2  output  DATA_W  read port 2 data
result_w  output  DATA_W  selected writeback value (to forwarding muxes)
wb_count  output  CNT_W  number of committed register writes

Behaviour:
- Writeback mux: result_w = memtoreg_w ? readdata_w : execout_w; purely combinational, zero latency.
- Commit condition: commit = regwrite_w AND (writereg_w != 0). On rising clk edge with commit, entry[writereg_w] <= result_w.
- Register 0 hardwired: never written; reads of index 0 return 0 on both ports regardless of bypass or history.
- regwrite_w = 1 with writereg_w = 0: no storage change, wb_count unchanged.
- Read ports: combinational (asynchronous) lookup of ra1/ra2; both ports independent, may address the same entry.
- Read of an entry written on the current edge: new value visible on rd1/rd2 immediately after that edge (no extra latency).
- wb_count: increments by 1 on each edge with commit; wraps from 2**CNT_W-1 to 0, no saturation.
- Reset (reset = 0): asynchronously forces every entry to 0 and wb_count to 0; rd1/rd2 consequently read 0; result_w remains combinational from inputs. While reset is low, commits are ignored. Reset asserted mid-cycle, including on the same edge as a commit, takes priority; the write is lost.
- First rising edge after reset deasserts performs a normal commit if commit is true.
- X or undriven memtoreg_w does not need to be handled; inputs are assumed clean after reset.

Optional Feature:
Macro WB_REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read bypass. If commit is true and ra1 (ra2) equals writereg_w, rd1 (rd2) returns result_w combinationally, before the edge. This removes the WB->ID hazard without a half-cycle write.
- Not defined: rd1/rd2 return the stored value only. The value being written appears after the rising edge; the hazard unit must stall or forward this case.
- Either build: index 0 still reads 0.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pull reset low mid-cycle -> rd1(ra1=5) = 0 immediately, wb_count = 0; release reset, read r5 -> 0.
- Mux and commit: regwrite_w=1, memtoreg_w=0, execout_w=0x12345678, readdata_w=0xAAAA5555, writereg_w=7, one edge -> rd1(ra1=7) = 0x12345678, wb_count = 1. Repeat with memtoreg_w=1 to r8 -> rd2(ra2=8) = 0xAAAA5555, wb_count = 2.
- r0 protection: regwrite_w=1, writereg_w=0, execout_w=0xFFFFFFFF, edge -> rd1(ra1=0) = 0, wb_count unchanged.
- Same-cycle read/write: r9 holds 0x11, drive commit to r9 with 0x22, ra1=ra2=9, sample before edge -> 0x22 with WB_REGFILE_BYPASS_EN, 0x11 without; after edge -> 0x22 in both builds.
- regwrite_w=0 with writereg_w=3, execout_w=0x5 -> r3 unchanged, wb_count unchanged.
- Counter wrap: CNT_W=4, 17 commits to r1 -> wb_count = 1.
